fpu_mult_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one FPU_Multiplication_Function_v2 instance among NREQ requesters.

---
 rtl/fpu_mult_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fpu_mult_arbiter.sv
// Round-robin sequencer sharing one FPU multiplier among NREQ clients.
// Optional macro FPU_ARB_TIMEOUT_EN enables a WAIT-state timeout.
module fpu_mult_arbiter #(
    parameter int W      = 32,
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int TO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_data_x_i,
    input  logic [NREQ*W-1:0] req_data_y_i,
    input  logic [2*NREQ-1:0] req_round_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [W-1:0]      rsp_result_o,
    output logic              rsp_ovf_o,
    output logic              rsp_unf_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              fpu_beg_o,
    output logic              fpu_ack_o,
    output logic [W-1:0]      fpu_mx_o,
    output logic [W-1:0]      fpu_my_o,
    output logic [1:0]        fpu_round_o,
    input  logic              fpu_ready_i,
    input  logic [W-1:0]      fpu_result_i,
    input  logic              fpu_ovf_i,
    input  logic              fpu_unf_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_x;
    logic [W-1:0]   r_y;
    logic [1:0]     r_rnd;
    logic [W-1:0]   r_res;
    logic           r_ovf;
    logic           r_unf;
    logic [IDW-1:0] w_gnt;
    logic           w_gnt_vld;
    logic           w_take;
    logic           w_done;
    logic           w_to;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;

    assign w_to = (r_state == S_WAIT) && !fpu_ready_i
               && (r_cnt == CW'(TO_CYC - 1));
    assign rsp_err_o = r_err;
`else
    assign w_to      = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    // Lowest offset from the pointer wins, so scan offsets high to low.
    always_comb begin
        int j;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(r_ptr) + k) % NREQ;
            if (req_valid_i[j]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = IDW'(j);
            end
        end
    end

    assign w_take = !rst && (r_state == S_IDLE) && w_gnt_vld;
    assign w_done = (r_state == S_WAIT) && fpu_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (w_take) begin
            req_ready_o[w_gnt] = 1'b1;
        end
    end

    always_comb begin
        w_next    = r_state;
        fpu_ack_o = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_take) w_next = S_LAUNCH;
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (w_done || w_to) begin
                    fpu_ack_o = !rst;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_rnd   <= '0;
            r_res   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_id  <= w_gnt;
                r_x   <= req_data_x_i[int'(w_gnt)*W +: W];
                r_y   <= req_data_y_i[int'(w_gnt)*W +: W];
                r_rnd <= req_round_i[int'(w_gnt)*2 +: 2];
                r_ptr <= (int'(w_gnt) == NREQ - 1) ? '0
                                                   : w_gnt + 1'b1;
            end
            if (w_done) begin
                r_res <= fpu_result_i;
                r_ovf <= fpu_ovf_i;
                r_unf <= fpu_unf_i;
            end else if (w_to) begin
                r_res <= '0;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_LAUNCH) r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
            if (w_done) r_err <= 1'b0;
            else if (w_to) r_err <= 1'b1;
        end
    end
`endif

    assign busy_o       = (r_state != S_IDLE);
    assign fpu_beg_o    = (r_state == S_LAUNCH);
    assign rsp_valid_o  = (r_state == S_RESP);
    assign rsp_id_o     = r_id;
    assign rsp_result_o = r_res;
    assign rsp_ovf_o    = r_ovf;
    assign rsp_unf_o    = r_unf;
    assign fpu_mx_o     = r_x;
    assign fpu_my_o     = r_y;
    assign fpu_round_o  = r_rnd;

endmodule
